// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction arbiter: FSM state encoding
// and the address/data field widths of a single-byte I2C transfer.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    RUN        = 3'd3,
    FINISH     = 3'd4
  } state_t;

endpackage

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// Round-robin winner selection: returns the first set request bit found
// searching ptr+1, ptr+2, ... modulo N_REQ. Purely combinational.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  // Scan from farthest to nearest so the candidate closest after ptr wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned; otherwise a latch would be inferred.
    idx   = '0;
    valid = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[PTR_W'((int'(ptr) + k) % N_REQ)]) begin
        idx   = PTR_W'((int'(ptr) + k) % N_REQ);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master between N_REQ
// requesters. Latches the winner's address/data/rw, strobes m_send for one
// cycle, follows m_busy to completion and pulses done (and err on failure)
// back to the winner.
// Optional: define I2C_ARB_TIMEOUT_EN to bound how long a transaction may
// hold m_busy high (TIMEOUT cycles); otherwise RUN waits indefinitely.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int START_WAIT = 2048,
  parameter int TIMEOUT    = 1048575
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [I2C_ADDR_W*N_REQ-1:0] req_addr,
  input  logic [I2C_DATA_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]          req_rw,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  output logic                      m_send,
  input  logic                      m_busy,
  output logic [I2C_ADDR_W-1:0]     m_addr,
  output logic [I2C_DATA_W-1:0]     m_data,
  output logic                      m_rw,
  output logic                      arb_busy
);

  localparam int          PTR_W      = $clog2(N_REQ);
  localparam logic [11:0] START_LAST = 12'(START_WAIT - 1);

  // Parameter sanity: counters are 12 and 20 bits wide.
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("i2c_txn_arbiter: N_REQ must be in 2..8");
  end
  if (START_WAIT < 1 || START_WAIT > 4096) begin : g_bad_start_wait
    $error("i2c_txn_arbiter: START_WAIT must be in 1..4096");
  end
  if (TIMEOUT < 1 || TIMEOUT > 1048576) begin : g_bad_timeout
    $error("i2c_txn_arbiter: TIMEOUT must be in 1..1048576");
  end

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [11:0]      start_cnt;
  logic             err_flag;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT - 1);
  logic [19:0] run_cnt;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign arb_busy = (state != IDLE);

  // Transaction sequencer: arbitration, master handshake, completion pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= PTR_W'(N_REQ - 1);
      owner     <= '0;
      start_cnt <= '0;
      err_flag  <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      m_send    <= 1'b0;
      m_addr    <= '0;
      m_data    <= '0;
      m_rw      <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      run_cnt   <= '0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // reads the pre-edge values; the strobes below default low each cycle.
      m_send <= 1'b0;
      done   <= '0;
      err    <= '0;
      case (state)
        IDLE: begin
          // A master still busy (e.g. after a reset or timeout) blocks grants.
          if (!m_busy && pick_valid) begin
            gnt    <= N_REQ'(1) << pick_idx;
            owner  <= pick_idx;
            m_addr <= req_addr[int'(pick_idx) * I2C_ADDR_W +: I2C_ADDR_W];
            m_data <= req_data[int'(pick_idx) * I2C_DATA_W +: I2C_DATA_W];
            m_rw   <= req_rw[pick_idx];
            m_send <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          start_cnt <= '0;
          err_flag  <= 1'b0;
          state     <= WAIT_START;
        end
        WAIT_START: begin
          if (m_busy) begin
`ifdef I2C_ARB_TIMEOUT_EN
            run_cnt <= '0;
`endif
            state <= RUN;
          end else if (start_cnt == START_LAST) begin
            err_flag <= 1'b1;
            state    <= FINISH;
          end else begin
            start_cnt <= start_cnt + 12'd1;
          end
        end
        RUN: begin
`ifdef I2C_ARB_TIMEOUT_EN
          if (!m_busy) begin
            state <= FINISH;
          end else if (run_cnt == TIMEOUT_LAST) begin
            err_flag <= 1'b1;
            state    <= FINISH;
          end else begin
            run_cnt <= run_cnt + 20'd1;
          end
`else
          if (!m_busy) begin
            state <= FINISH;
          end
`endif
        end
        FINISH: begin
          done  <= gnt;
          err   <= err_flag ? gnt : '0;
          ptr   <= owner;
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed self-checking bench for i2c_txn_arbiter (default build, N_REQ=4,
// START_WAIT=2048). A small I2C master model raises m_busy a programmable
// number of cycles after m_send and holds it for a programmable length.
module tb_i2c_txn_arbiter;

  localparam int N  = 4;
  localparam int SW = 2048;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_rw;
  logic [N-1:0]  gnt, done, err;
  logic          m_send;
  logic          m_busy = 1'b0;
  logic [6:0]    m_addr;
  logic [7:0]    m_data;
  logic          m_rw;
  logic          arb_busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  i2c_txn_arbiter #(.N_REQ(N), .START_WAIT(SW), .TIMEOUT(1048575)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_rw   (req_rw),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .m_send   (m_send),
    .m_busy   (m_busy),
    .m_addr   (m_addr),
    .m_data   (m_data),
    .m_rw     (m_rw),
    .arb_busy (arb_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Master model: rise_dly cycles after m_send busy goes high for busy_len
  // clock edges. With mdl_auto=0, m_busy simply follows busy_force.
  bit mdl_auto   = 1'b0;
  bit busy_force = 1'b0;
  int rise_dly   = 3;
  int busy_len   = 40;
  int cd = 0, bl = 0;

  always @(negedge clk) begin
    if (!mdl_auto) begin
      m_busy = busy_force;
      cd = 0;
      bl = 0;
    end else if (m_send) begin
      if (rise_dly == 0) begin
        m_busy = 1'b1;
        bl = busy_len;
      end else begin
        cd = rise_dly;
      end
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        m_busy = 1'b1;
        bl = busy_len;
      end
    end else if (bl > 0) begin
      bl--;
      if (bl == 0) m_busy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_fields(input int i, input logic [6:0] a, input logic [7:0] d, input logic r);
    req_addr[i*7 +: 7] = a;
    req_data[i*8 +: 8] = d;
    req_rw[i]          = r;
  endtask

  // Observe one transaction from the current negedge until done pulses (or the
  // budget expires). Times are in cycles relative to the call.
  task automatic run_txn(input int budget, input int drop_at, input logic [N-1:0] drop_mask,
                         output int send_at, output logic [N-1:0] send_gnt,
                         output logic [6:0] s_addr, output logic [7:0] s_data, output logic s_rw,
                         output int done_at, output logic [N-1:0] done_v, output logic [N-1:0] err_v,
                         output int sends, output bit stable);
    int start;
    start = cyc;
    send_at = -1; send_gnt = '0; s_addr = '0; s_data = '0; s_rw = 1'b0;
    done_at = -1; done_v = '0; err_v = '0; sends = 0; stable = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cyc - start == drop_at) req = req & ~drop_mask;
      if (done !== '0) begin
        done_at = cyc - start;
        done_v  = done;
        err_v   = err;
        break;
      end
      if (m_send) begin
        sends++;
        if (send_at < 0) begin
          send_at = cyc - start; send_gnt = gnt;
          s_addr = m_addr; s_data = m_data; s_rw = m_rw;
        end
      end else if (send_at >= 0 &&
                   ({gnt, m_addr, m_data, m_rw} !== {send_gnt, s_addr, s_data, s_rw})) begin
        stable = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_addr = '0; req_data = '0; req_rw = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({gnt, done, err, m_send, m_addr, m_data, m_rw, arb_busy} !== '0) begin
      $display("FAIL reset_outputs: got gnt=%b done=%b err=%b send=%b addr=%h data=%h rw=%b busy=%b required all 0",
               gnt, done, err, m_send, m_addr, m_data, m_rw, arb_busy);
    end else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({gnt, m_send, arb_busy} !== '0) begin
      $display("FAIL idle_after_reset: got gnt=%b send=%b busy=%b required 0", gnt, m_send, arb_busy);
    end else n_pass++;
  endtask

  task automatic test_contention();
    int exp_idx [6] = '{0, 1, 3, 0, 1, 3};
    logic [6:0] ea [N] = '{7'h21, 7'h32, 7'h00, 7'h54};
    logic [7:0] ed [N] = '{8'h10, 8'h20, 8'h00, 8'h40};
    logic       er [N] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int send_at, done_at, sends; bit stable;
    logic [N-1:0] sg, dv, ev; logic [6:0] sa; logic [7:0] sd; logic sr;
    logic [N-1:0] eg;
    for (int i = 0; i < N; i++) set_fields(i, ea[i], ed[i], er[i]);
    mdl_auto = 1'b1; rise_dly = 3; busy_len = 5;
    req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      run_txn(200, -1, '0, send_at, sg, sa, sd, sr, done_at, dv, ev, sends, stable);
      eg = 4'b0001 << exp_idx[k];
      n_total++;
      if ({sg, sa, sd, sr} !== {eg, ea[exp_idx[k]], ed[exp_idx[k]], er[exp_idx[k]]}) begin
        $display("FAIL contention_grant%0d: got gnt=%b addr=%h data=%h rw=%b required gnt=%b addr=%h data=%h rw=%b",
                 k, sg, sa, sd, sr, eg, ea[exp_idx[k]], ed[exp_idx[k]], er[exp_idx[k]]);
      end else n_pass++;
      n_total++;
      if ({dv, ev} !== {eg, 4'b0000}) begin
        $display("FAIL contention_done%0d: got done=%b err=%b required done=%b err=0000", k, dv, ev, eg);
      end else n_pass++;
      n_total++;
      if (send_at != 1 || done_at - send_at != 10 || sends != 1 || !stable) begin
        $display("FAIL contention_timing%0d: got send_at=%0d done_delta=%0d sends=%0d stable=%0b required 1/10/1/1",
                 k, send_at, done_at - send_at, sends, stable);
      end else n_pass++;
    end
    req = '0;
  endtask

  task automatic test_single();
    int send_at, done_at, sends; bit stable;
    logic [N-1:0] sg, dv, ev; logic [6:0] sa; logic [7:0] sd; logic sr;
    set_fields(0, 7'h1A, 8'hA5, 1'b0);
    mdl_auto = 1'b1; rise_dly = 3; busy_len = 40;
    @(negedge clk);
    req = 4'b0001;
    run_txn(200, -1, '0, send_at, sg, sa, sd, sr, done_at, dv, ev, sends, stable);
    req = '0;
    n_total++;
    if (send_at != 1 || sends != 1) begin
      $display("FAIL single_send: got send_at=%0d sends=%0d required 1 and 1", send_at, sends);
    end else n_pass++;
    n_total++;
    if ({sg, sa, sd, sr} !== {4'b0001, 7'h1A, 8'hA5, 1'b0}) begin
      $display("FAIL single_fields: got gnt=%b addr=%h data=%h rw=%b required 0001 1a a5 0", sg, sa, sd, sr);
    end else n_pass++;
    n_total++;
    if (!stable) begin
      $display("FAIL single_stable: got gnt/m_* changed during transaction required held");
    end else n_pass++;
    n_total++;
    if ({dv, ev} !== {4'b0001, 4'b0000} || done_at - send_at != 45) begin
      $display("FAIL single_done: got done=%b err=%b delta=%0d required 0001 0000 45", dv, ev, done_at - send_at);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if ({done, gnt, arb_busy} !== '0) begin
      $display("FAIL single_after: got done=%b gnt=%b busy=%b required 0", done, gnt, arb_busy);
    end else n_pass++;
  endtask

  // ptr is 0 here: all four requesting picks 1. Busy rises inside ISSUE.
  task automatic test_simultaneous_fast_busy();
    int send_at, done_at, sends; bit stable;
    logic [N-1:0] sg, dv, ev; logic [6:0] sa; logic [7:0] sd; logic sr;
    set_fields(1, 7'h3C, 8'h5A, 1'b1);
    mdl_auto = 1'b1; rise_dly = 0; busy_len = 2;
    req = 4'b1111;
    run_txn(100, -1, '0, send_at, sg, sa, sd, sr, done_at, dv, ev, sends, stable);
    req = '0;
    n_total++;
    if ({sg, sa, sd, sr} !== {4'b0010, 7'h3C, 8'h5A, 1'b1}) begin
      $display("FAIL simultaneous_grant: got gnt=%b addr=%h data=%h rw=%b required 0010 3c 5a 1", sg, sa, sd, sr);
    end else n_pass++;
    n_total++;
    if ({dv, ev} !== {4'b0010, 4'b0000} || done_at - send_at != 4) begin
      $display("FAIL fast_busy_done: got done=%b err=%b delta=%0d required 0010 0000 4", dv, ev, done_at - send_at);
    end else n_pass++;
  endtask

  task automatic test_withdraw();
    int send_at, done_at, sends, extra; bit stable;
    logic [N-1:0] sg, dv, ev; logic [6:0] sa; logic [7:0] sd; logic sr;
    set_fields(1, 7'h44, 8'h99, 1'b0);
    mdl_auto = 1'b1; rise_dly = 3; busy_len = 20;
    @(negedge clk);
    req = 4'b0010;
    run_txn(200, 10, 4'b0010, send_at, sg, sa, sd, sr, done_at, dv, ev, sends, stable);
    n_total++;
    if ({sg, dv, ev} !== {4'b0010, 4'b0010, 4'b0000} || done_at - send_at != 25 || !stable) begin
      $display("FAIL withdraw_done: got gnt=%b done=%b err=%b delta=%0d stable=%0b required 0010 0010 0000 25 1",
               sg, dv, ev, done_at - send_at, stable);
    end else n_pass++;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_send || gnt !== '0) extra++;
    end
    n_total++;
    if (extra != 0) begin
      $display("FAIL withdraw_regrant: got %0d cycles with send/grant required 0", extra);
    end else n_pass++;
  endtask

  task automatic test_no_response();
    int send_at, done_at, sends; bit stable;
    logic [N-1:0] sg, dv, ev; logic [6:0] sa; logic [7:0] sd; logic sr;
    set_fields(2, 7'h77, 8'h0F, 1'b1);
    mdl_auto = 1'b0; busy_force = 1'b0;
    @(negedge clk);
    req = 4'b0100;
    run_txn(SW + 100, -1, '0, send_at, sg, sa, sd, sr, done_at, dv, ev, sends, stable);
    req = '0;
    n_total++;
    if ({sg, dv, ev} !== {4'b0100, 4'b0100, 4'b0100} || !stable) begin
      $display("FAIL noresp_err: got gnt=%b done=%b err=%b stable=%0b required 0100 0100 0100 1", sg, dv, ev, stable);
    end else n_pass++;
    n_total++;
    if (done_at - send_at != SW + 2) begin
      $display("FAIL noresp_delay: got %0d required %0d", done_at - send_at, SW + 2);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if ({arb_busy, gnt, err} !== '0) begin
      $display("FAIL noresp_idle: got busy=%b gnt=%b err=%b required 0", arb_busy, gnt, err);
    end else n_pass++;
  endtask

  task automatic test_reset_in_run();
    int send_at, done_at, sends, extra; bit stable;
    logic [N-1:0] sg, dv, ev; logic [6:0] sa; logic [7:0] sd; logic sr;
    set_fields(0, 7'h11, 8'h22, 1'b0);
    mdl_auto = 1'b1; rise_dly = 3; busy_len = 1000;
    @(negedge clk);
    req = 4'b0001;
    repeat (15) @(negedge clk);
    n_total++;
    if ({arb_busy, gnt, m_busy} !== {1'b1, 4'b0001, 1'b1}) begin
      $display("FAIL run_before_reset: got busy=%b gnt=%b m_busy=%b required 1 0001 1", arb_busy, gnt, m_busy);
    end else n_pass++;
    busy_force = 1'b1; mdl_auto = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({gnt, done, err, m_send, m_addr, m_data, m_rw, arb_busy} !== '0) begin
      $display("FAIL reset_in_run: got gnt=%b done=%b err=%b send=%b addr=%h data=%h rw=%b busy=%b required all 0",
               gnt, done, err, m_send, m_addr, m_data, m_rw, arb_busy);
    end else n_pass++;
    set_fields(0, 7'h5D, 8'hC3, 1'b1);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_send || gnt !== '0 || arb_busy || done !== '0) extra++;
    end
    n_total++;
    if (extra != 0) begin
      $display("FAIL grant_while_busy: got %0d active cycles required 0", extra);
    end else n_pass++;
    #1 busy_force = 1'b0;
    @(negedge clk);
    #1 rise_dly = 3; busy_len = 4; mdl_auto = 1'b1;
    run_txn(100, -1, '0, send_at, sg, sa, sd, sr, done_at, dv, ev, sends, stable);
    req = '0;
    n_total++;
    if ({sg, sa, sd, sr} !== {4'b0001, 7'h5D, 8'hC3, 1'b1} || send_at != 1) begin
      $display("FAIL post_reset_issue: got gnt=%b addr=%h data=%h rw=%b send_at=%0d required 0001 5d c3 1 1",
               sg, sa, sd, sr, send_at);
    end else n_pass++;
    n_total++;
    if ({dv, ev} !== {4'b0001, 4'b0000} || done_at - send_at != 9) begin
      $display("FAIL post_reset_done: got done=%b err=%b delta=%0d required 0001 0000 9", dv, ev, done_at - send_at);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_simultaneous_fast_busy();
    test_withdraw();
    test_no_response();
    test_reset_in_run();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
